// File: rtl/data_mem_port_arbiter_pkg.sv
// data_mem_port_arbiter_pkg: shared arbiter state encodings and default widths
package data_mem_port_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_WIDTH        = 4;
    typedef enum logic {
        ARB_PIPE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;
endpackage

// File: rtl/data_mem_port_arbiter_sat_counter.sv
// sat_counter: counter that clears on clr and stops at LIMIT
// ports: clk/rst, inc (count up), clr (back to zero), at_limit (cnt == LIMIT)
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    logic [WIDTH-1:0] cnt;
    assign at_limit = (cnt == WIDTH'(LIMIT));
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/data_mem_port_arbiter.sv
// data_mem_port_arbiter: shares the data memory between the Memory stage and a debug/DMA port
// ports: CLK/RST; pipeline side MemReqM/MemWriteM/ALUOutM/WriteDataM -> ReadDataM, StallMem;
// debug side dbg_valid/dbg_we/dbg_addr/dbg_wdata -> dbg_ready/dbg_rvalid/dbg_rdata;
// memory side mem_we/mem_addr/mem_wdata <- mem_rdata
module data_mem_port_arbiter
    import data_mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallMem,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    arb_state_e state;
    logic pipe_gnt, dbg_gnt, starve_inc, starve_clr, starve_at_limit;
    assign pipe_gnt   = (state == ARB_PIPE) && MemReqM;
    // debug wins in the forced slot, or opportunistically when the pipeline is idle
    assign dbg_gnt    = dbg_valid && ((state == ARB_FORCE) || !MemReqM);
    assign dbg_ready  = dbg_gnt && !RST;
    assign StallMem   = (state == ARB_FORCE);
    assign mem_we     = !RST && (pipe_gnt ? MemWriteM : (dbg_gnt && dbg_we));
    assign mem_addr   = dbg_gnt ? dbg_addr : ALUOutM;
    assign mem_wdata  = dbg_gnt ? dbg_wdata : WriteDataM;
    assign ReadDataM  = mem_rdata;
    assign starve_inc = pipe_gnt && dbg_valid;
    assign starve_clr = dbg_gnt || !dbg_valid || (state == ARB_FORCE);
    sat_counter #(
        .WIDTH(CNT_WIDTH),
        .LIMIT(STARVE_LIMIT - 1)
    ) u_starve (
        .clk     (CLK),
        .rst     (RST),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .at_limit(starve_at_limit)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ARB_PIPE;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= (starve_inc && starve_at_limit) ? ARB_FORCE : ARB_PIPE;
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// tb_data_mem_port_arbiter: scenario tasks with a read-data scoreboard against a behavioural memory
module tb_data_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MemReqM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        dbg_valid = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int checks = 0;
    int failures = 0;

    data_mem_port_arbiter dut (
        .CLK(CLK), .RST(RST), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallMem(StallMem), .dbg_valid(dbg_valid), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge CLK) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_rvalid(input string name);
        checks++;
        if (dbg_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s_rvalid got=%b exp=1", name, dbg_rvalid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty got=%h exp=queued", name, dbg_rdata);
        end else begin
            exp_v = exp_q.pop_front();
            if (dbg_rdata !== exp_v) begin
                failures++;
                $display("FAIL %s_rdata got=%h exp=%h", name, dbg_rdata, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; MemReqM = 1'b1; dbg_valid = 1'b1; dbg_we = 1'b0; ALUOutM = 32'h44; dbg_addr = 32'h10;
        tick();
        tick();
        checks++;
        if ({StallMem, dbg_ready, dbg_rvalid, mem_we} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_ctrl got=%b exp=0000", {StallMem, dbg_ready, dbg_rvalid, mem_we});
        end
        checks++;
        if (dbg_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=0", dbg_rdata);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (dbg_ready !== 1'b0 || mem_addr !== 32'h44 || StallMem !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_grant got=rdy%b addr%h stall%b exp=rdy0 addr44 stall0", dbg_ready, mem_addr, StallMem);
        end
        MemReqM = 1'b0; dbg_valid = 1'b0;
        tick();
    endtask

    task automatic test_idle_slot();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({dbg_ready, mem_we, StallMem} !== 3'b110 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL idle_write got=rdy%b we%b stall%b addr%h exp=rdy1 we1 stall0 addr10", dbg_ready, mem_we, StallMem, mem_addr);
        end
        tick();
        dbg_we = 1'b0;
        #1;
        checks++;
        if (dbg_ready !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL idle_read_gnt got=rdy%b we%b exp=rdy1 we0", dbg_ready, mem_we);
        end
        exp_q.push_back(32'hDEADBEEF);
        tick();
        dbg_valid = 1'b0;
        check_rvalid("idle_read");
        tick();
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_rvalid_pulse got=%b exp=0", dbg_rvalid);
        end
    endtask

    task automatic test_starvation();
        MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h30;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (dbg_ready !== 1'b0 || StallMem !== 1'b0) begin
                failures++;
                $display("FAIL starve_blocked_c%0d got=rdy%b stall%b exp=rdy0 stall0", c, dbg_ready, StallMem);
            end
            tick();
        end
        checks++;
        if (StallMem !== 1'b1 || dbg_ready !== 1'b1 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL starve_force got=stall%b rdy%b addr%h exp=stall1 rdy1 addr10", StallMem, dbg_ready, mem_addr);
        end
        exp_q.push_back(32'hDEADBEEF);
        tick();
        dbg_valid = 1'b0;
        check_rvalid("starve_read");
        checks++;
        if (StallMem !== 1'b0) begin
            failures++;
            $display("FAIL starve_release got=%b exp=0", StallMem);
        end
        MemReqM = 1'b0;
        tick();
    endtask

    task automatic test_same_addr();
        MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'h2;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (StallMem !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1) begin
            failures++;
            $display("FAIL order_dbg_write got=stall%b we%b wd%h exp=stall1 we1 wd1", StallMem, mem_we, mem_wdata);
        end
        tick();
        dbg_valid = 1'b0;
        checks++;
        if (StallMem !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h2) begin
            failures++;
            $display("FAIL order_pipe_write got=stall%b we%b wd%h exp=stall0 we1 wd2", StallMem, mem_we, mem_wdata);
        end
        tick();
        MemReqM = 1'b0; MemWriteM = 1'b0;
        checks++;
        if (mem[8'h20] !== 32'h2) begin
            failures++;
            $display("FAIL order_final got=%h exp=2", mem[8'h20]);
        end
        dbg_valid = 1'b1; dbg_we = 1'b0;
        exp_q.push_back(32'h2);
        tick();
        dbg_valid = 1'b0;
        check_rvalid("order_readback");
        tick();
    endtask

    task automatic test_dropped_valid();
        MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h30;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h55;
        for (int c = 0; c < 4; c++) tick();
        dbg_valid = 1'b0;
        #1;
        checks++;
        if (StallMem !== 1'b1 || mem_we !== 1'b0 || dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle_stall got=stall%b we%b rdy%b exp=stall1 we0 rdy0", StallMem, mem_we, dbg_ready);
        end
        tick();
        checks++;
        if (dbg_rvalid !== 1'b0 || StallMem !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_rvalid got=rv%b stall%b exp=rv0 stall0", dbg_rvalid, StallMem);
        end
        // counter must have restarted: a fresh request waits the full four cycles again
        dbg_valid = 1'b1; dbg_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (StallMem !== 1'b0 || dbg_ready !== 1'b0) begin
                failures++;
                $display("FAIL drop_restart_c%0d got=stall%b rdy%b exp=stall0 rdy0", c, StallMem, dbg_ready);
            end
            tick();
        end
        checks++;
        if (StallMem !== 1'b1 || dbg_ready !== 1'b1) begin
            failures++;
            $display("FAIL drop_reforce got=stall%b rdy%b exp=stall1 rdy1", StallMem, dbg_ready);
        end
        exp_q.push_back(32'hDEADBEEF);
        tick();
        dbg_valid = 1'b0;
        check_rvalid("drop_reread");
        MemReqM = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        #1;
        checks++;
        if (dbg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt got=%b exp=1", dbg_ready);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; dbg_valid = 1'b0;
        checks++;
        if (dbg_rvalid !== 1'b0 || StallMem !== 1'b0) begin
            failures++;
            $display("FAIL midrst_read got=rv%b stall%b exp=rv0 stall0", dbg_rvalid, StallMem);
        end
        tick();
        MemReqM = 1'b1; ALUOutM = 32'h30;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h77;
        for (int c = 0; c < 4; c++) tick();
        RST = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_force_write got=we%b rdy%b exp=we0 rdy0", mem_we, dbg_ready);
        end
        tick();
        RST = 1'b0; MemReqM = 1'b0; dbg_valid = 1'b0;
        checks++;
        if (StallMem !== 1'b0 || mem[8'h40] !== 32'h0) begin
            failures++;
            $display("FAIL midrst_force_state got=stall%b mem%h exp=stall0 mem0", StallMem, mem[8'h40]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_idle_slot();
        test_starvation();
        test_same_addr();
        test_dropped_valid();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
